// File: rtl/sd_decimator_if.sv
// Sample output handshake between the sigma-delta decimator and its consumer.
// The data width follows the decimation ratio: 2*OSR_LOG2+1 bits.
interface sd_decimator_if #(
  parameter int OSR_LOG2 = 8
);
  localparam int OUT_W = 2 * OSR_LOG2 + 1;

  logic [OUT_W-1:0] sampleData;
  logic             sampleValid;
  logic             sampleReady;

  modport master (
    output sampleData,
    output sampleValid,
    input  sampleReady
  );

  modport slave (
    input  sampleData,
    input  sampleValid,
    output sampleReady
  );
endinterface

// File: rtl/sd_decimator.sv
// Sigma-delta front end: synchronises the external comparator and drives
// the 1-bit feedback DAC. The resulting bitstream is reduced by a sinc^2
// CIC decimator (R = 2^OSR_LOG2), and samples are offered on a valid/ready
// handshake with a sticky overrun flag.
module sd_decimator #(
  parameter int CLK_DIV  = 4,
  parameter int OSR_LOG2 = 8
) (
  input  logic           sysClk,
  input  logic           sysRstb,
  input  logic           enable,
  input  logic           cmpIn,
  output logic           fbOut,
  output logic           overrun,
  sd_decimator_if.master smp
);
  localparam int OUT_W = 2 * OSR_LOG2 + 1;
  localparam int TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic [TMR_W-1:0]    timer;
  logic                tick;
  logic [OSR_LOG2-1:0] dec_cnt;
  logic                dec_tick;
  logic                fb_q;
  logic [OUT_W-1:0]    int1;
  logic [OUT_W-1:0]    int2;
  logic [OUT_W-1:0]    int1_next;
  logic                comb1_go;
  logic                comb2_go;
  logic [OUT_W-1:0]    c1;
  logic [OUT_W-1:0]    d1;
  logic [OUT_W-1:0]    d2;
  logic [OUT_W-1:0]    data_q;
  logic                valid_q;
  logic                overrun_q;

  assign tick      = enable && (timer == TMR_LAST);
  assign dec_tick  = tick && (dec_cnt == '1);
  assign int1_next = int1 + OUT_W'(sync_q2);

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge sysClk) begin
    if (!sysRstb) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= cmpIn;
      sync_q2 <= sync_q1;
    end
  end

  // Modulator bit timer: one tick every CLK_DIV enabled clocks
  always_ff @(posedge sysClk) begin
    if (!sysRstb) begin
      timer <= '0;
    end else if (enable) begin
      timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
    end
  end

  // Feedback bit, integrator pair and decimation counter advance on each tick
  always_ff @(posedge sysClk) begin
    if (!sysRstb) begin
      fb_q    <= 1'b0;
      int1    <= '0;
      int2    <= '0;
      dec_cnt <= '0;
    end else if (tick) begin
      fb_q    <= sync_q2;
      int1    <= int1_next;
      int2    <= int2 + int1_next;
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // First comb stage one edge after the decimating tick; runs regardless of enable
  always_ff @(posedge sysClk) begin
    if (!sysRstb) begin
      comb1_go <= 1'b0;
      comb2_go <= 1'b0;
      c1       <= '0;
      d1       <= '0;
    end else begin
      comb1_go <= dec_tick;
      comb2_go <= comb1_go;
      if (comb1_go) begin
        c1 <= int2 - d1;
        d1 <= int2;
      end
    end
  end

  // Second comb stage and output handshake; a sample arriving while the
  // previous one is still held and not being taken is dropped (overrun), but
  // d2 still advances so later samples stay consistent with the bitstream
  always_ff @(posedge sysClk) begin
    if (!sysRstb) begin
      d2        <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (valid_q && smp.sampleReady) begin
        valid_q <= 1'b0;
      end
      if (comb2_go) begin
        d2 <= c1;
        if (valid_q && !smp.sampleReady) begin
          overrun_q <= 1'b1;
        end else begin
          data_q  <= c1 - d2;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign fbOut           = fb_q;
  assign overrun         = overrun_q;
  assign smp.sampleData  = data_q;
  assign smp.sampleValid = valid_q;
endmodule

// File: tb/tb_sd_decimator.sv
// Scoreboard bench for sd_decimator with OSR_LOG2=3 (R=8, 7-bit samples).
// dut1 runs with CLK_DIV=1, dut4 with CLK_DIV=4. Expected samples are
// pushed when stimulus is issued; per-DUT monitors pop on each transfer.
module tb_sd_decimator;
  logic clk;
  logic rstb1, en1, cmp1, fb1, ovr1;
  logic rstb4, en4, cmp4, fb4, ovr4;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_n   = 0;
  int   q1[$];
  int   q4[$];

  sd_decimator_if #(.OSR_LOG2(3)) if1 ();
  sd_decimator_if #(.OSR_LOG2(3)) if4 ();

  sd_decimator #(.CLK_DIV(1), .OSR_LOG2(3)) dut1 (
    .sysClk(clk), .sysRstb(rstb1), .enable(en1), .cmpIn(cmp1),
    .fbOut(fb1), .overrun(ovr1), .smp(if1)
  );

  sd_decimator #(.CLK_DIV(4), .OSR_LOG2(3)) dut4 (
    .sysClk(clk), .sysRstb(rstb4), .enable(en4), .cmpIn(cmp4),
    .fbOut(fb4), .overrun(ovr4), .smp(if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s got %0d want %0d", name, got, want);
    else n_pass++;
  endtask

  // Monitors: every transfer must match the oldest expected sample
  always @(negedge clk) begin
    if (if1.sampleValid && if1.sampleReady) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_unexpected_sample got %0d want none", if1.sampleData);
      end else begin
        chk("dut1_sample", 32'(if1.sampleData), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (if4.sampleValid && if4.sampleReady) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL dut4_unexpected_sample got %0d want none", if4.sampleData);
      end else begin
        chk("dut4_sample", 32'(if4.sampleData), 32'(q4.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Advance to 1 time unit after edge k counted from the last release
  task automatic go(input int k);
    while (edge_n < k) step(1);
  endtask

  task automatic drain(input int which, input int budget);
    int n = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (which == 1) begin
      chk("dut1_samples_left", q1.size(), 0);
      q1.delete();
    end else begin
      chk("dut4_samples_left", q4.size(), 0);
      q4.delete();
    end
  endtask

  initial begin
    rstb1 = 1'b0; en1 = 1'b1; cmp1 = 1'b1; if1.sampleReady = 1'b1;
    rstb4 = 1'b0; en4 = 1'b1; cmp4 = 1'b0; if4.sampleReady = 1'b1;
    step(2);
    chk("rst1_fb", fb1, 0);
    chk("rst1_data", 32'(if1.sampleData), 0);
    chk("rst1_valid", if1.sampleValid, 0);
    chk("rst1_overrun", ovr1, 0);
    chk("rst4_fb", fb4, 0);
    chk("rst4_valid", if4.sampleValid, 0);

    // A: constant ones from release. The synchroniser feeds zeros on the
    // first two ticks, so frame 1 holds 6 ones: I2 = 21, 105, 253, 465.
    rstb1 = 1'b1; edge_n = 0;
    go(2); chk("A_fb_edge2", fb1, 0);
    go(3); chk("A_fb_edge3", fb1, 1);
    q1.push_back(21); q1.push_back(63); q1.push_back(64); q1.push_back(64);
    drain(1, 60);
    chk("A_overrun", ovr1, 0);

    // B: zeros, then ones from after edge 20 (bits 1 from tick 23).
    // I2 = 0, 0, 3, 55, 171, 351 -> 0, 0, 3, 49, 64, 64
    rstb1 = 1'b0; step(2);
    cmp1 = 1'b0;
    rstb1 = 1'b1; edge_n = 0;
    q1.push_back(0); q1.push_back(0); q1.push_back(3);
    q1.push_back(49); q1.push_back(64); q1.push_back(64);
    go(20); cmp1 = 1'b1;
    drain(1, 80);

    // D: ready low; first sample 21 held, second (edge 18) dropped
    rstb1 = 1'b0; step(2);
    if1.sampleReady = 1'b0;
    rstb1 = 1'b1; edge_n = 0;
    go(9);  chk("D_valid_e9", if1.sampleValid, 0);
    go(10); chk("D_valid_e10", if1.sampleValid, 1);
            chk("D_data_e10", 32'(if1.sampleData), 21);
    go(17); chk("D_ovr_e17", ovr1, 0);
            chk("D_data_e17", 32'(if1.sampleData), 21);
    go(18); chk("D_ovr_e18", ovr1, 1);
            chk("D_valid_e18", if1.sampleValid, 1);
            chk("D_data_e18", 32'(if1.sampleData), 21);
    go(27); chk("D_ovr_e27", ovr1, 1);
            chk("D_data_e27", 32'(if1.sampleData), 21);
    // Held 21 goes first; 4th sample (edge 34) is 212 - 148 = 64
    q1.push_back(21); q1.push_back(64);
    go(28); if1.sampleReady = 1'b1;
    go(29); chk("D_valid_e29", if1.sampleValid, 0);
    go(33); chk("D_valid_e33", if1.sampleValid, 0);
    go(34); chk("D_valid_e34", if1.sampleValid, 1);
    go(35); if1.sampleReady = 1'b0;
    drain(1, 4);

    // E: reset with sample 5 pending and overrun set
    go(44); chk("E_valid_pending", if1.sampleValid, 1);
    rstb1 = 1'b0;
    step(1);
    chk("E_fb", fb1, 0);
    chk("E_data", 32'(if1.sampleData), 0);
    chk("E_valid", if1.sampleValid, 0);
    chk("E_overrun", ovr1, 0);
    en1 = 1'b0; if1.sampleReady = 1'b1;
    step(1);
    // Restart with synchroniser pre-filled: all 8 bits of frame 1 are ones
    rstb1 = 1'b1; edge_n = 0;
    go(3); chk("E_fb_frozen", fb1, 0);
    en1 = 1'b1;
    q1.push_back(36); q1.push_back(64); q1.push_back(64);

    // F: enable low for 20 clocks inside frame 2 shifts later samples by 20
    go(13); chk("F_valid_e13", if1.sampleValid, 1);
    go(15); en1 = 1'b0;
    go(25); chk("F_fb_hold", fb1, 1);
    go(35); en1 = 1'b1;
    go(40); chk("F_valid_e40", if1.sampleValid, 0);
    go(41); chk("F_valid_e41", if1.sampleValid, 1);
    drain(1, 40);
    chk("F_overrun", ovr1, 0);
    rstb1 = 1'b0;

    // C: CLK_DIV=4, cmpIn toggles every 4 clocks -> bits 1,0,1,0...
    // I2 = k(k+1) at 2k ticks: 20, 72, 156, 272 -> 20, 32, 32, 32
    cmp4 = 1'b1;
    rstb4 = 1'b1; edge_n = 0;
    q4.push_back(20); q4.push_back(32); q4.push_back(32); q4.push_back(32);
    fork
      begin
        for (int j = 0; j < 36; j++) begin
          repeat (4) @(posedge clk);
          #1;
          cmp4 = ~cmp4;
        end
      end
      begin
        go(33); chk("C_valid_e33", if4.sampleValid, 0);
        go(34); chk("C_valid_e34", if4.sampleValid, 1);
        go(35); chk("C_valid_e35", if4.sampleValid, 0);
        go(65); chk("C_valid_e65", if4.sampleValid, 0);
        go(66); chk("C_valid_e66", if4.sampleValid, 1);
        drain(4, 100);
        chk("C_overrun", ovr4, 0);
      end
    join
    rstb4 = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
